// File: rtl/next_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | next_pkg                                                             |
// | Mode encodings and default vectors for the fetch next-address unit.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package next_pkg;

    localparam logic [2:0] NEXT_INC  = 3'b000;
    localparam logic [2:0] NEXT_JUMP = 3'b001;
    localparam logic [2:0] NEXT_JZ   = 3'b010;
    localparam logic [2:0] NEXT_CALL = 3'b011;
    localparam logic [2:0] NEXT_RET  = 3'b100;
    localparam logic [2:0] NEXT_EXEC = 3'b101;
    localparam logic [2:0] NEXT_HOLD = 3'b110;

    localparam logic [15:0] NEXT_RESET_VECTOR = 16'h0000;
    localparam logic [15:0] NEXT_TRAP_VECTOR  = 16'h0010;

endpackage
`default_nettype wire

// File: rtl/pilha_retorno.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pilha_retorno                                                        |
// | Parametrised LIFO return stack; push-when-full/pop-when-empty ignored.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pilha_retorno #(
    parameter int DATA_WIDTH = 16,
    parameter int RS_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         pushData,
    output logic [DATA_WIDTH-1:0]         top,
    output logic [$clog2(RS_DEPTH+1)-1:0] level,
    output logic                          empty,
    output logic                          full
);

    localparam int LW = $clog2(RS_DEPTH + 1);
    localparam int IW = $clog2(RS_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [RS_DEPTH];
    logic [LW-1:0]         r_level;
    logic [IW-1:0]         w_topIdx;
    logic                  w_empty;
    logic                  w_full;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LW'(RS_DEPTH));
    assign w_topIdx = IW'(r_level - 1'b1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_level <= '0;
        end else if (push && !w_full) begin
            r_level <= r_level + 1'b1;
        end else if (pop && !w_empty) begin
            r_level <= r_level - 1'b1;
        end
    end

    // Entries are never reset: the empty flag masks stale contents on top.
    always_ff @(posedge clk) begin
        if (reset_n && push && !w_full) begin
            r_mem[IW'(r_level)] <= pushData;
        end
    end

    assign top   = w_empty ? '0 : r_mem[w_topIdx];
    assign level = r_level;
    assign empty = w_empty;
    assign full  = w_full;

endmodule
`default_nettype wire

// File: rtl/next_addr_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | next_addr_unit                                                       |
// | Registered PC with six-way next-address select and return stack.     |
// | Build option: NEXT_TRAP_EN routes stack faults to TRAP_VECTOR.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module next_addr_unit
    import next_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    RS_DEPTH     = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(NEXT_RESET_VECTOR),
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'(NEXT_TRAP_VECTOR)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          stall,
    input  logic [2:0]                    select_next,
    input  logic [DATA_WIDTH-1:0]         dado_pilha,
    input  logic [DATA_WIDTH-1:0]         endereco_prog,
    input  logic                          cond_zero,
    output logic [DATA_WIDTH-1:0]         next,
    output logic [DATA_WIDTH-1:0]         ret_topo,
    output logic [$clog2(RS_DEPTH+1)-1:0] rs_nivel,
    output logic                          rs_vazia,
    output logic                          rs_cheia,
    output logic                          erro
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_erro;
    logic [DATA_WIDTH-1:0] w_pcInc;
    logic [DATA_WIDTH-1:0] w_pcNext;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fault;

    assign w_pcInc = r_pc + 1'b1;

`ifndef NEXT_TRAP_EN
    // Without trapping the trap vector has no consumer.
    logic [DATA_WIDTH-1:0] w_unusedTrap;
    assign w_unusedTrap = TRAP_VECTOR;
`endif

    always_comb begin
        w_pcNext = r_pc;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_fault  = 1'b0;
        if (!stall) begin
            case (select_next)
                NEXT_INC:  w_pcNext = w_pcInc;
                NEXT_JUMP: w_pcNext = endereco_prog;
                NEXT_JZ:   w_pcNext = cond_zero ? endereco_prog : w_pcInc;
                NEXT_CALL: begin
                    if (rs_cheia) begin
                        w_fault = 1'b1;
`ifdef NEXT_TRAP_EN
                        w_pcNext = TRAP_VECTOR;
`else
                        w_pcNext = r_pc;
`endif
                    end else begin
                        w_push   = 1'b1;
                        w_pcNext = endereco_prog;
                    end
                end
                NEXT_RET: begin
                    if (rs_vazia) begin
                        w_fault = 1'b1;
`ifdef NEXT_TRAP_EN
                        w_pcNext = TRAP_VECTOR;
`else
                        w_pcNext = RESET_VECTOR;
`endif
                    end else begin
                        w_pop    = 1'b1;
                        w_pcNext = ret_topo;
                    end
                end
                NEXT_EXEC: w_pcNext = dado_pilha;
                NEXT_HOLD: w_pcNext = r_pc;
                default:   w_pcNext = r_pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc   <= RESET_VECTOR;
            r_erro <= 1'b0;
        end else if (!stall) begin
            r_pc <= w_pcNext;
            if (w_fault) begin
                r_erro <= 1'b1;
            end
        end
    end

    pilha_retorno #(
        .DATA_WIDTH (DATA_WIDTH),
        .RS_DEPTH   (RS_DEPTH)
    ) u_pilha (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (w_push),
        .pop      (w_pop),
        .pushData (w_pcInc),
        .top      (ret_topo),
        .level    (rs_nivel),
        .empty    (rs_vazia),
        .full     (rs_cheia)
    );

    assign next = r_pc;
    assign erro = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_next_addr_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_next_addr_unit                                                    |
// | Directed self-checking bench; expectations follow NEXT_TRAP_EN.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_next_addr_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [2:0]  select_next;
    logic [15:0] dado_pilha;
    logic [15:0] endereco_prog;
    logic        cond_zero;
    logic [15:0] next;
    logic [15:0] ret_topo;
    logic [3:0]  rs_nivel;
    logic        rs_vazia;
    logic        rs_cheia;
    logic        erro;

    int total = 0;
    int fails = 0;

`ifdef NEXT_TRAP_EN
    localparam logic [15:0] OVF_PC = 16'h0010;
    localparam logic [15:0] UNF_PC = 16'h0010;
`else
    localparam logic [15:0] OVF_PC = 16'h0407;
    localparam logic [15:0] UNF_PC = 16'h0000;
`endif

    next_addr_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .select_next   (select_next),
        .dado_pilha    (dado_pilha),
        .endereco_prog (endereco_prog),
        .cond_zero     (cond_zero),
        .next          (next),
        .ret_topo      (ret_topo),
        .rs_nivel      (rs_nivel),
        .rs_vazia      (rs_vazia),
        .rs_cheia      (rs_cheia),
        .erro          (erro)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [2:0] sel, input logic [15:0] prog,
                        input logic [15:0] dado, input logic cz);
        select_next   = sel;
        endereco_prog = prog;
        dado_pilha    = dado;
        cond_zero     = cz;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        step(3'b000, 16'h0, 16'h0, 1'b0);
        chk("rst_next",  32'(next), 32'h0);
        chk("rst_nivel", 32'(rs_nivel), 32'd0);
        chk("rst_vazia", 32'(rs_vazia), 32'd1);
        chk("rst_cheia", 32'(rs_cheia), 32'd0);
        chk("rst_topo",  32'(ret_topo), 32'h0);
        chk("rst_erro",  32'(erro), 32'd0);

        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(3'b000, 16'h0, 16'h0, 1'b0);
            chk("inc_next", 32'(next), 32'(i));
        end
        chk("inc_vazia", 32'(rs_vazia), 32'd1);
        chk("inc_erro",  32'(erro), 32'd0);

        step(3'b010, 16'h0100, 16'h0, 1'b1);
        chk("jz_taken", 32'(next), 32'h0100);
        step(3'b010, 16'h0100, 16'h0, 1'b0);
        chk("jz_fall", 32'(next), 32'h0101);
        step(3'b001, 16'h0BEE, 16'h0, 1'b0);
        chk("jump", 32'(next), 32'h0BEE);
        step(3'b101, 16'h0, 16'hFFFF, 1'b0);
        chk("exec", 32'(next), 32'hFFFF);
        step(3'b000, 16'h0, 16'h0, 1'b0);
        chk("inc_wrap", 32'(next), 32'h0000);
        step(3'b110, 16'h1234, 16'h5678, 1'b1);
        chk("hold", 32'(next), 32'h0000);
        step(3'b111, 16'h1234, 16'h5678, 1'b1);
        chk("reserved", 32'(next), 32'h0000);

        step(3'b001, 16'h0005, 16'h0, 1'b0);
        step(3'b011, 16'h0200, 16'h0, 1'b0);
        chk("call_next",  32'(next), 32'h0200);
        chk("call_topo",  32'(ret_topo), 32'h0006);
        chk("call_nivel", 32'(rs_nivel), 32'd1);
        chk("call_vazia", 32'(rs_vazia), 32'd0);
        step(3'b100, 16'h0, 16'h0, 1'b0);
        chk("ret_next",  32'(next), 32'h0006);
        chk("ret_vazia", 32'(rs_vazia), 32'd1);
        chk("ret_topo",  32'(ret_topo), 32'h0);

        // Eight calls from pc=6 fill the stack; the last pushes 0x0407.
        for (int k = 0; k < 8; k++) begin
            step(3'b011, 16'h0400 + 16'(k), 16'h0, 1'b0);
            if (k == 6) chk("call7_cheia", 32'(rs_cheia), 32'd0);
        end
        chk("call8_next",  32'(next), 32'h0407);
        chk("call8_nivel", 32'(rs_nivel), 32'd8);
        chk("call8_cheia", 32'(rs_cheia), 32'd1);
        chk("call8_topo",  32'(ret_topo), 32'h0407);
        chk("call8_erro",  32'(erro), 32'd0);
        step(3'b011, 16'h0500, 16'h0, 1'b0);
        chk("ovf_erro",  32'(erro), 32'd1);
        chk("ovf_next",  32'(next), 32'(OVF_PC));
        chk("ovf_nivel", 32'(rs_nivel), 32'd8);
        chk("ovf_topo",  32'(ret_topo), 32'h0407);
        step(3'b100, 16'h0, 16'h0, 1'b0);
        chk("ovf_ret_next",  32'(next), 32'h0407);
        chk("ovf_ret_nivel", 32'(rs_nivel), 32'd7);
        chk("ovf_ret_topo",  32'(ret_topo), 32'h0406);
        chk("ovf_ret_erro",  32'(erro), 32'd1);

        reset_n = 1'b0;
        step(3'b000, 16'h0, 16'h0, 1'b0);
        reset_n = 1'b1;
        chk("rst2_erro", 32'(erro), 32'd0);
        step(3'b001, 16'h0123, 16'h0, 1'b0);
        step(3'b100, 16'h0, 16'h0, 1'b0);
        chk("unf_erro", 32'(erro), 32'd1);
        chk("unf_next", 32'(next), 32'(UNF_PC));
        step(3'b000, 16'h0, 16'h0, 1'b0);
        chk("unf_inc_next", 32'(next), 32'(UNF_PC + 16'd1));
        chk("unf_sticky",   32'(erro), 32'd1);

        stall = 1'b1;
        step(3'b011, 16'h0700, 16'h0, 1'b0);
        step(3'b011, 16'h0700, 16'h0, 1'b0);
        chk("stall_next",  32'(next), 32'(UNF_PC + 16'd1));
        chk("stall_nivel", 32'(rs_nivel), 32'd0);
        stall = 1'b0;

        step(3'b011, 16'h0700, 16'h0, 1'b0);
        chk("call3_nivel", 32'(rs_nivel), 32'd1);
        reset_n = 1'b0;
        step(3'b101, 16'h0, 16'h0ABC, 1'b0);
        chk("rstx_next",  32'(next), 32'h0000);
        chk("rstx_vazia", 32'(rs_vazia), 32'd1);
        chk("rstx_nivel", 32'(rs_nivel), 32'd0);
        chk("rstx_erro",  32'(erro), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/next_addr_unit.md
# next_addr_unit

Registered next-address unit for the stack CPU's fetch stage, and the sequential successor of the combinational next-address selector. It holds the program counter and selects its next value from six sources: increment, immediate target, conditional target, call, return and indirect from the data stack. It contains a parametrised hardware return stack for CALL/RET. Its output drives the program memory address each cycle.

## Interface
- DATA_WIDTH, 16: width of addresses, operands and return-stack entries
- RS_DEPTH, 8: return-stack entries; must be ≥2
- RESET_VECTOR, 0: PC value after reset and after an untrapped underflow
- TRAP_VECTOR, 16'h0010: PC value on a stack fault when trapping is compiled in
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- stall  in  1  high: all state holds, select ignored
- select_next  in  3  next-address mode, encodings below
- dado_pilha  in  DATA_WIDTH  data-stack top, the indirect (EXEC) target
- endereco_prog  in  DATA_WIDTH  immediate target from program memory
- cond_zero  in  1  data-stack top equals zero, used by JZ
- next  out  DATA_WIDTH  registered PC
- ret_topo  out  DATA_WIDTH  registered return-stack top; 0 when empty
- rs_nivel  out  $clog2(RS_DEPTH+1)  occupied entries
- rs_vazia / rs_cheia  out  1 each  return stack empty / full
- erro  out  1  sticky stack-fault flag; cleared only by reset

## Operation
Modes (pc = current `next`, all additions mod 2^DATA_WIDTH):
- 000 INC: pc+1.
- 001 JUMP: endereco_prog.
- 010 JZ: endereco_prog if cond_zero, else pc+1.
- 011 CALL: push pc+1, then load endereco_prog.
- 100 RET: pop, then load the popped value.
- 101 EXEC: dado_pilha.
- 110 HOLD and 111 (reserved): pc unchanged, no stack activity.

Faults:
- CALL while rs_cheia is an overflow. The stack is unchanged and erro sets.
- RET while rs_vazia is an underflow. erro sets.
- The PC result of a fault depends on the configuration macro.

Other rules:
- PC increment wraps: 16'hFFFF+1 = 16'h0000.
- stall has priority over every mode, including faults.
- reset_n has priority over stall.

## Timing
- One-cycle latency: the mode and operands sampled at edge N appear on `next` and the stack outputs after edge N.
- No combinational path from any input to any output.
- Reset (reset_n low at an edge):
  - next=RESET_VECTOR, rs_nivel=0, rs_vazia=1, rs_cheia=0, ret_topo=0, erro=0.
  - Reset taken mid-CALL/RET discards the operation and empties the stack.
- CALL at rs_nivel=RS_DEPTH-1 succeeds; rs_cheia rises on the same edge.
- RET at rs_nivel=1 succeeds; rs_vazia rises and ret_topo becomes 0.
- Back-to-back CALL/RET on consecutive cycles is legal. After CALL A at pc=P then RET, next = P+1.

## Configuration
- NEXT_TRAP_EN defined:
  - any overflow or underflow loads TRAP_VECTOR into the PC;
  - on overflow, the stack is unchanged.
- NEXT_TRAP_EN undefined:
  - overflow: PC holds at the current value;
  - underflow: PC loads RESET_VECTOR.
- erro behaves identically in both builds.

## Structure
- Package `next_pkg` holds:
  - the mode encodings NEXT_INC, NEXT_JUMP, NEXT_JZ, NEXT_CALL, NEXT_RET, NEXT_EXEC, NEXT_HOLD;
  - the default vectors.
- Sub-module `pilha_retorno` implements the return stack:
  - parametrised LIFO (DATA_WIDTH, RS_DEPTH), register array plus pointer;
  - push/pop inputs, top, level, empty and full outputs;
  - ignores push-when-full and pop-when-empty.
- The top level holds the PC register, mode decode, fault logic and sticky erro.

## Test plan
- Reset release, then 3 cycles INC → next = 0, 1, 2, 3; rs_vazia=1; erro=0.
- JZ to 16'h0100: cond_zero=1 → 16'h0100; then cond_zero=0 → 16'h0101. With pc=16'hFFFF and INC → 16'h0000.
- CALL 16'h0200 at pc=16'h0005, then RET → next 16'h0200, ret_topo 16'h0006, rs_nivel 1; then next 16'h0006, rs_vazia=1.
- 9 CALLs with RS_DEPTH=8 → first 8 push with rs_cheia=1 after the 8th. The 9th sets erro; PC is TRAP_VECTOR with NEXT_TRAP_EN, otherwise holds; rs_nivel stays 8.
- RET on empty → erro=1; next = TRAP_VECTOR with NEXT_TRAP_EN, RESET_VECTOR without. erro stays 1 through later valid ops until reset_n=0.
- CALL with stall=1 for 2 cycles → no change. EXEC with dado_pilha=16'h0ABC plus reset_n=0 on the same edge → next=RESET_VECTOR and the stack is empty.
